// File: rtl/gpu_command_encoder.sv
// gpu_command_encoder: serialises one draw request into the GPU
// instruction word sequence (set_xy1, set_xy2/set_radius, draw).
// Ports: clk, rst (async, active-high); req_valid_i/req_ready_o with
//   req_shape_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i;
//   opcode_o/parameters_o/command_o with cmd_ready_i backpressure;
//   busy_o (sequence in progress), err_o (one-cycle reject pulse).
// Optional macro GPU_CIRCLE_EN: builds circle support (RAD state,
//   opcode 0110). Undefined: circle requests are consumed and err_o
//   pulses.
module gpu_command_encoder #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int PARAM_BITS   = 25
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_shape_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  output logic [3:0]              opcode_o,
  output logic [PARAM_BITS-1:0]   parameters_o,
  output logic                    command_o,
  input  logic                    cmd_ready_i,
  output logic                    busy_o,
  output logic                    err_o
);

  localparam int XY_BITS  = WIDTH_BITS + HEIGHT_BITS;
  localparam int COL_BITS = 3 * CHANNEL_BITS;

  localparam logic [3:0] OP_RST  = 4'b0000;
  localparam logic [3:0] OP_XY1  = 4'b0001;
  localparam logic [3:0] OP_XY2  = 4'b0010;
  localparam logic [3:0] OP_LINE = 4'b0100;
  localparam logic [3:0] OP_RECT = 4'b0101;

  localparam logic [1:0] SH_RECT   = 2'd1;
  localparam logic [1:0] SH_CIRCLE = 2'd2;
  localparam logic [1:0] SH_RESET  = 2'd3;

`ifdef GPU_CIRCLE_EN
  localparam logic [3:0] OP_RAD  = 4'b0011;
  localparam logic [3:0] OP_CIRC = 4'b0110;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_XY1,
    S_XY2,
    S_DRAW,
    S_RST
`ifdef GPU_CIRCLE_EN
    , S_RAD
`endif
  } state_t;

  state_t                  state_q;
  logic [3:0]              opcode_q;
  logic [PARAM_BITS-1:0]   params_q;
  logic                    command_q;
  logic                    busy_q;
  logic                    ready_q;
  logic                    err_q;

  logic [1:0]              shape_q;
  logic [WIDTH_BITS-1:0]   x2_q;
  logic [HEIGHT_BITS-1:0]  y2_q;
  logic [CHANNEL_BITS-1:0] r_q;
  logic [CHANNEL_BITS-1:0] g_q;
  logic [CHANNEL_BITS-1:0] b_q;
`ifdef GPU_CIRCLE_EN
  logic [WIDTH_BITS-1:0]   rad_q;
`else
  logic                    unused_rad;
  assign unused_rad = ^rad_i;
`endif

  logic xfer;
  assign xfer = command_q && cmd_ready_i;

  function automatic logic [PARAM_BITS-1:0] pack_xy(
    input logic [WIDTH_BITS-1:0]  x,
    input logic [HEIGHT_BITS-1:0] y
  );
    logic [PARAM_BITS-1:0] p;
    p = '0;
    p[XY_BITS-1:0] = {y, x};
    return p;
  endfunction

  function automatic logic [PARAM_BITS-1:0] pack_col(
    input logic [CHANNEL_BITS-1:0] r,
    input logic [CHANNEL_BITS-1:0] g,
    input logic [CHANNEL_BITS-1:0] b
  );
    logic [PARAM_BITS-1:0] p;
    p = '0;
    p[COL_BITS-1:0] = {r, g, b};
    return p;
  endfunction

`ifdef GPU_CIRCLE_EN
  function automatic logic [PARAM_BITS-1:0] pack_rad(
    input logic [WIDTH_BITS-1:0] rad
  );
    logic [PARAM_BITS-1:0] p;
    p = '0;
    p[WIDTH_BITS-1:0] = rad;
    return p;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      params_q  <= '0;
      command_q <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      shape_q   <= '0;
      x2_q      <= '0;
      y2_q      <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
`ifdef GPU_CIRCLE_EN
      rad_q     <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            shape_q <= req_shape_i;
            x2_q    <= x2_i;
            y2_q    <= y2_i;
            r_q     <= r_i;
            g_q     <= g_i;
            b_q     <= b_i;
`ifdef GPU_CIRCLE_EN
            rad_q   <= rad_i;
`endif
            if (req_shape_i == SH_RESET) begin
              state_q   <= S_RST;
              opcode_q  <= OP_RST;
              params_q  <= '0;
              command_q <= 1'b1;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
`ifndef GPU_CIRCLE_EN
            end else if (req_shape_i == SH_CIRCLE) begin
              // Circle not built: consume, flag, stay ready.
              err_q <= 1'b1;
`endif
            end else begin
              state_q   <= S_XY1;
              opcode_q  <= OP_XY1;
              params_q  <= pack_xy(x1_i, y1_i);
              command_q <= 1'b1;
              busy_q    <= 1'b1;
              ready_q   <= 1'b0;
            end
          end
        end
        S_XY1: begin
          if (xfer) begin
            state_q  <= S_XY2;
            opcode_q <= OP_XY2;
            params_q <= pack_xy(x2_q, y2_q);
`ifdef GPU_CIRCLE_EN
            if (shape_q == SH_CIRCLE) begin
              state_q  <= S_RAD;
              opcode_q <= OP_RAD;
              params_q <= pack_rad(rad_q);
            end
`endif
          end
        end
        S_XY2: begin
          if (xfer) begin
            state_q  <= S_DRAW;
            opcode_q <= (shape_q == SH_RECT) ? OP_RECT : OP_LINE;
            params_q <= pack_col(r_q, g_q, b_q);
          end
        end
`ifdef GPU_CIRCLE_EN
        S_RAD: begin
          if (xfer) begin
            state_q  <= S_DRAW;
            opcode_q <= OP_CIRC;
            params_q <= pack_col(r_q, g_q, b_q);
          end
        end
`endif
        default: begin
          // DRAW and RST both end the sequence on their transfer.
          if (xfer || !(state_q inside {S_DRAW, S_RST})) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            params_q  <= '0;
            command_q <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign opcode_o     = opcode_q;
  assign parameters_o = params_q;
  assign command_o    = command_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_gpu_command_encoder.sv
// tb_gpu_command_encoder: directed bench with a word-queue model of
// the encoder and a per-cycle compare process.
module tb_gpu_command_encoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  shape;
  logic [9:0]  x1, x2, rad;
  logic [8:0]  y1, y2;
  logic [7:0]  r, g, b;
  logic [3:0]  opcode;
  logic [24:0] params;
  logic        command;
  logic        cmd_ready;
  logic        busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [24:0] p;
  } word_t;

  word_t q[$];
  logic  err_exp = 1'b0;

`ifdef GPU_CIRCLE_EN
  localparam bit CIRC = 1'b1;
`else
  localparam bit CIRC = 1'b0;
`endif

  gpu_command_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_shape_i (shape),
    .x1_i        (x1),
    .y1_i        (y1),
    .x2_i        (x2),
    .y2_i        (y2),
    .rad_i       (rad),
    .r_i         (r),
    .g_i         (g),
    .b_i         (b),
    .opcode_o    (opcode),
    .parameters_o(params),
    .command_o   (command),
    .cmd_ready_i (cmd_ready),
    .busy_o      (busy),
    .err_o       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Expected word list for a request, from the packing rules.
  task automatic push_req();
    logic [24:0] xy1, xy2, col, rw;
    xy1 = 25'(y1) * 1024 + 25'(x1);
    xy2 = 25'(y2) * 1024 + 25'(x2);
    col = 25'(r) * 65536 + 25'(g) * 256 + 25'(b);
    rw  = 25'(rad);
    case (shape)
      2'd0, 2'd1: begin
        q.push_back('{4'd1, xy1});
        q.push_back('{4'd2, xy2});
        q.push_back('{4'd4 + 4'(shape), col});
      end
      2'd2: begin
        if (CIRC) begin
          q.push_back('{4'd1, xy1});
          q.push_back('{4'd3, rw});
          q.push_back('{4'd6, col});
        end
      end
      default: q.push_back('{4'd0, 25'd0});
    endcase
  endtask

  // Per-cycle compare: outputs follow from the pending word queue.
  initial begin
    logic nxt_err;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        err_exp = 1'b0;
      end else begin
        chk("ready", 32'(req_ready), 32'(q.size() == 0));
        chk("command", 32'(command), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("err", 32'(err), 32'(err_exp));
        if (q.size() != 0) begin
          chk("opcode", 32'(opcode), 32'(q[0].op));
          chk("params", 32'(params), 32'(q[0].p));
        end
        nxt_err = 1'b0;
        if (q.size() != 0) begin
          if (cmd_ready) void'(q.pop_front());
        end else if (req_valid) begin
          push_req();
          nxt_err = (shape == 2'd2) && !CIRC;
        end
        err_exp = nxt_err;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] s, input int ax1,
                         input int ay1, input int ax2, input int ay2,
                         input int arad, input int ar, input int ag,
                         input int ab);
    shape     = s;
    x1        = 10'(ax1);
    y1        = 9'(ay1);
    x2        = 10'(ax2);
    y2        = 9'(ay2);
    rad       = 10'(arad);
    r         = 8'(ar);
    g         = 8'(ag);
    b         = 8'(ab);
    req_valid = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready && !command && !busy) && n < 40);
    chk("idle_wait_in_budget", 32'(n < 40), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    cmd_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_command", 32'(command), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_params", 32'(params), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Line, no backpressure.
    set_req(0, 5, 7, 639, 479, 0, 'hFF, 'h80, 'h01);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("line_w1_op", 32'(opcode), 32'h1);
    chk("line_w1_p", 32'(params), 32'h0001C05);
    @(negedge clk);
    chk("line_w2_op", 32'(opcode), 32'h2);
    chk("line_w2_p", 32'(params), 32'h0077E7F);
    @(negedge clk);
    chk("line_w3_op", 32'(opcode), 32'h4);
    chk("line_w3_p", 32'(params), 32'h0FF8001);
    @(negedge clk);
    chk("line_ready_4th", 32'(req_ready), 32'd1);
    tick();

    // Rect with a 3-cycle stall on the XY2 word.
    set_req(1, 10, 20, 30, 40, 0, 1, 2, 3);
    tick();
    req_valid = 1'b0;
    tick();
    cmd_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_op", 32'(opcode), 32'h2);
      chk("stall_p", 32'(params), 32'h000A01E);
      tick();
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("rect_draw_op", 32'(opcode), 32'h5);
    chk("rect_draw_p", 32'(params), 32'h0010203);
    wait_idle();
    tick();

    // GPU reset word.
    set_req(3, 1, 2, 3, 4, 5, 6, 7, 8);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("grst_op", 32'(opcode), 32'h0);
    chk("grst_p", 32'(params), 32'h0);
    chk("grst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("grst_busy_end", 32'(busy), 32'd0);
    tick();

    // Circle.
    set_req(2, 320, 240, 0, 0, 100, 'h11, 'h22, 'h33);
    tick();
    req_valid = 1'b0;
`ifdef GPU_CIRCLE_EN
    @(negedge clk);
    chk("circ_w1_op", 32'(opcode), 32'h1);
    chk("circ_w1_p", 32'(params), 32'h003C140);
    @(negedge clk);
    chk("circ_w2_op", 32'(opcode), 32'h3);
    chk("circ_w2_p", 32'(params), 32'h64);
    @(negedge clk);
    chk("circ_w3_op", 32'(opcode), 32'h6);
    chk("circ_w3_p", 32'(params), 32'h0112233);
    wait_idle();
`else
    @(negedge clk);
    chk("circ_err_pulse", 32'(err), 32'd1);
    chk("circ_no_cmd", 32'(command), 32'd0);
    chk("circ_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("circ_err_end", 32'(err), 32'd0);
`endif
    tick();

    // Asynchronous reset while in XY2.
    set_req(0, 1, 2, 3, 4, 0, 9, 9, 9);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_command", 32'(command), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    set_req(0, 100, 200, 300, 400, 0, 4, 5, 6);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("arst_restart_op", 32'(opcode), 32'h1);
    chk("arst_restart_p", 32'(params), 32'h0032064);
    wait_idle();
    tick();

    // Valid held: second request waits for the first to finish.
    set_req(0, 11, 22, 33, 44, 0, 1, 1, 1);
    tick();
    set_req(1, 55, 66, 77, 88, 0, 2, 2, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 20);
    chk("hold_ready_cycles", 32'(n), 32'd4);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("hold_b_op", 32'(opcode), 32'h1);
    chk("hold_b_p", 32'(params), 32'h0010837);
    wait_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
